ahb_ram_arbiter: RTL and testbench

// - Two-master arbiter/sequencer in front of the single-slave AHB RAM bridge (ahb2ram).
// - Shares it between m0 (instruction fetch) and m1 (load/store) via round-robin.
// - Converts simple req/ack requests into the bridge's hsel/haddr/hwrite/hwdata sequence.
// - Packs access type into haddr[29:27]; returns read data with a one-cycle ack.

---
 rtl/ahb_ram_arbiter.sv | 271 +++++++++++++++++++++++++++
 tb/tb_ahb_ram_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_ram_arbiter.sv
// -----------------------------------------------------------------------------
// ahb_ram_arbiter
//
// Two-master round-robin arbiter and sequencer in front of the single-slave
// AHB RAM bridge (ahb2ram). Master 0 is the instruction-fetch port, master 1
// the load/store port. A simple req/ack handshake per master is converted into
// the bridge's hsel/haddr/hwrite/hwdata sequence; completion is a one-cycle
// ack pulse carrying the read data.
//
// Transaction sequence: IDLE -> ADDR (hsel=1 for one cycle) -> WAIT (until
// hready) -> WDATA (writes only) -> RESP (ack pulse) -> IDLE.
// The access type is forwarded on haddr[29:27]; only addr[15:0] reaches the
// bridge.
//
// Optional feature (compile-time macro ARB_TIMEOUT_EN):
//   defined   - WAIT is bounded to TIMEOUT cycles; on expiry the granted
//               master receives ack with err=1 and rdata=0. Adds m0_err/m1_err.
//   undefined - WAIT stalls until hready; no err ports.
//
// Parameters:
//   ADDR_W   address width (>= 30, haddr packing uses bit 29)
//   DATA_W   data width
//   TIMEOUT  WAIT-cycle limit, ARB_TIMEOUT_EN only, must be >= 4
//
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   mX_req/we/addr/wdata/rwtyp   master X request (held until ack)
//   mX_ack/rdata[/err]     master X completion (registered)
//   hsel/hwrite/haddr/hwdata     bridge request outputs (registered)
//   hready/hrdata/hresp    bridge response inputs (hresp ignored)
// -----------------------------------------------------------------------------
module ahb_ram_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  // master 0 (instruction fetch)
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [2:0]        m0_rwtyp,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
`ifdef ARB_TIMEOUT_EN
  output logic              m0_err,
`endif
  // master 1 (load/store)
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [2:0]        m1_rwtyp,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
`ifdef ARB_TIMEOUT_EN
  output logic              m1_err,
`endif
  // bridge side
  output logic              hsel,
  output logic              hwrite,
  output logic [ADDR_W-1:0] haddr,
  output logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hresp
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WAIT  = 3'd2,
    WDATA = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t              state_r, state_s;
  logic                grant_r, grant_s;   // 0 = m0, 1 = m1
  logic                rr_ptr_r, rr_ptr_s; // favoured master on contention
  logic                gsel_s;

  logic                hsel_r, hsel_s;
  logic                hwrite_r, hwrite_s;
  logic [ADDR_W-1:0]   haddr_r, haddr_s;
  logic [DATA_W-1:0]   hwdata_r, hwdata_s;

  logic                m0_ack_r, m0_ack_s;
  logic                m1_ack_r, m1_ack_s;
  logic [DATA_W-1:0]   m0_rdata_r, m0_rdata_s;
  logic [DATA_W-1:0]   m1_rdata_r, m1_rdata_s;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic                m0_err_r, m0_err_s;
  logic                m1_err_r, m1_err_s;
`else
  localparam int timeout_unused = TIMEOUT;
`endif

  // Bridge response code and upper address bits are intentionally not used.
  logic unused_s;
  assign unused_s = ^{hresp, m0_addr[ADDR_W-1:16], m1_addr[ADDR_W-1:16]};

  // Next-state and next-output logic; every output is the image of a register.
  always_comb begin
    state_s    = state_r;
    grant_s    = grant_r;
    rr_ptr_s   = rr_ptr_r;
    gsel_s     = 1'b0;
    hsel_s     = 1'b0;
    hwrite_s   = hwrite_r;
    haddr_s    = haddr_r;
    hwdata_s   = hwdata_r;
    m0_ack_s   = 1'b0;
    m1_ack_s   = 1'b0;
    m0_rdata_s = {DATA_W{1'b0}};
    m1_rdata_s = {DATA_W{1'b0}};
`ifdef ARB_TIMEOUT_EN
    cnt_s      = cnt_r;
    m0_err_s   = 1'b0;
    m1_err_s   = 1'b0;
`endif

    case (state_r)
      IDLE: begin
        if (m0_req || m1_req) begin
          // Contention resolved by rr_ptr; a lone requester always wins.
          if (m0_req && m1_req) begin
            gsel_s = rr_ptr_r;
          end else begin
            gsel_s = m1_req;
          end
          grant_s = gsel_s;
          hsel_s  = 1'b1;
          haddr_s = {ADDR_W{1'b0}};
          if (gsel_s) begin
            hwrite_s       = m1_we;
            haddr_s[29:27] = m1_rwtyp;
            haddr_s[15:0]  = m1_addr[15:0];
            hwdata_s       = m1_wdata;
          end else begin
            hwrite_s       = m0_we;
            haddr_s[29:27] = m0_rwtyp;
            haddr_s[15:0]  = m0_addr[15:0];
            hwdata_s       = m0_wdata;
          end
          state_s = ADDR;
        end else begin
          state_s = IDLE;
        end
      end

      ADDR: begin
        state_s = WAIT;
`ifdef ARB_TIMEOUT_EN
        cnt_s   = {CNT_W{1'b0}};
`endif
      end

      WAIT: begin
        if (hready) begin
          if (hwrite_r) begin
            state_s = WDATA;
          end else begin
            // Read completes here: ack is registered so it appears in RESP.
            state_s = RESP;
            if (grant_r) begin
              m1_ack_s   = 1'b1;
              m1_rdata_s = hrdata;
            end else begin
              m0_ack_s   = 1'b1;
              m0_rdata_s = hrdata;
            end
          end
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
          // TIMEOUT WAIT cycles without hready: abort with error, no data.
          state_s = RESP;
          if (grant_r) begin
            m1_ack_s = 1'b1;
            m1_err_s = 1'b1;
          end else begin
            m0_ack_s = 1'b1;
            m0_err_s = 1'b1;
          end
        end else begin
          cnt_s   = cnt_r + CNT_W'(1);
          state_s = WAIT;
`endif
        end else begin
          state_s = WAIT;
        end
      end

      WDATA: begin
        // hwdata is held this cycle while the bridge performs the write.
        state_s = RESP;
        if (grant_r) begin
          m1_ack_s = 1'b1;
        end else begin
          m0_ack_s = 1'b1;
        end
      end

      RESP: begin
        rr_ptr_s = ~grant_r;
        state_s  = IDLE;
      end

      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, arbitration and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      grant_r    <= 1'b0;
      rr_ptr_r   <= 1'b0;
      hsel_r     <= 1'b0;
      hwrite_r   <= 1'b0;
      haddr_r    <= {ADDR_W{1'b0}};
      hwdata_r   <= {DATA_W{1'b0}};
      m0_ack_r   <= 1'b0;
      m1_ack_r   <= 1'b0;
      m0_rdata_r <= {DATA_W{1'b0}};
      m1_rdata_r <= {DATA_W{1'b0}};
`ifdef ARB_TIMEOUT_EN
      cnt_r      <= {CNT_W{1'b0}};
      m0_err_r   <= 1'b0;
      m1_err_r   <= 1'b0;
`endif
    end else begin
      state_r    <= state_s;
      grant_r    <= grant_s;
      rr_ptr_r   <= rr_ptr_s;
      hsel_r     <= hsel_s;
      hwrite_r   <= hwrite_s;
      haddr_r    <= haddr_s;
      hwdata_r   <= hwdata_s;
      m0_ack_r   <= m0_ack_s;
      m1_ack_r   <= m1_ack_s;
      m0_rdata_r <= m0_rdata_s;
      m1_rdata_r <= m1_rdata_s;
`ifdef ARB_TIMEOUT_EN
      cnt_r      <= cnt_s;
      m0_err_r   <= m0_err_s;
      m1_err_r   <= m1_err_s;
`endif
    end
  end

  assign hsel     = hsel_r;
  assign hwrite   = hwrite_r;
  assign haddr    = haddr_r;
  assign hwdata   = hwdata_r;
  assign m0_ack   = m0_ack_r;
  assign m1_ack   = m1_ack_r;
  assign m0_rdata = m0_rdata_r;
  assign m1_rdata = m1_rdata_r;
`ifdef ARB_TIMEOUT_EN
  assign m0_err   = m0_err_r;
  assign m1_err   = m1_err_r;
`endif

endmodule

// File: tb/tb_ahb_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ahb_ram_arbiter
//
// Directed bench for ahb_ram_arbiter with a small ahb2ram bridge model:
// writes see hready in the first WAIT cycle and commit in the following cycle;
// reads take one wait state. Expected completions are queued when a request is
// issued and popped by a monitor whenever an ack appears.
// -----------------------------------------------------------------------------
module tb_ahb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [2:0]  m0_rwtyp, m1_rwtyp;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
`ifdef ARB_TIMEOUT_EN
  logic        m0_err, m1_err;
`endif
  logic        hsel, hwrite, hready, hresp;
  logic [31:0] haddr, hwdata, hrdata;

  always #5 clk = ~clk;

  ahb_ram_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rwtyp(m0_rwtyp), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
`ifdef ARB_TIMEOUT_EN
    .m0_err(m0_err),
`endif
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rwtyp(m1_rwtyp), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
`ifdef ARB_TIMEOUT_EN
    .m1_err(m1_err),
`endif
    .hsel(hsel), .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata),
    .hready(hready), .hrdata(hrdata), .hresp(hresp)
  );

  // ---------------- bridge model ----------------
  logic [31:0] mem [0:255];
  logic [1:0]  bphase;
  logic        bwr;
  logic [15:0] baddr;
  logic        force_nready;
  logic        preload;
  logic        wren;

  assign hresp  = 1'b0;
  assign hready = !force_nready && ((bphase == 2'd1 && bwr) || (bphase == 2'd2 && !bwr));
  assign hrdata = (bphase == 2'd2 && !bwr) ? mem[baddr[7:0]] : 32'h0;
  assign wren   = (bphase == 2'd2) && bwr;

  always @(posedge clk) begin
    if (preload) mem[8'h10] <= 32'hDEAD_BEEF;
    if (rst) begin
      bphase <= 2'd0;
      bwr    <= 1'b0;
      baddr  <= 16'h0;
    end else begin
      case (bphase)
        2'd0: if (hsel) begin bphase <= 2'd1; bwr <= hwrite; baddr <= haddr[15:0]; end
        2'd1: bphase <= 2'd2;
        2'd2: begin
          if (bwr) mem[baddr[7:0]] <= hwdata;
          bphase <= 2'd0;
        end
        default: bphase <= 2'd0;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        m;
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_err  = 0;
  int   ack_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic m, input logic [31:0] d, input logic e);
    exp_t x;
    x.m = m; x.d = d; x.e = e;
    exp_q.push_back(x);
  endtask

  // Ack monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t x;
    if (!rst && (m0_ack || m1_ack)) begin
      chk("ack_exclusive", {31'h0, m0_ack & m1_ack}, 32'h0);
      n_vec++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_ack observed=m0:%0b/m1:%0b expected=none", m0_ack, m1_ack);
      end
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        chk("ack_master", {31'h0, m1_ack}, {31'h0, x.m});
        chk("ack_rdata", m1_ack ? m1_rdata : m0_rdata, x.d);
`ifdef ARB_TIMEOUT_EN
        chk("ack_err", {31'h0, m1_ack ? m1_err : m0_err}, {31'h0, x.e});
`endif
      end
      ack_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic m, input logic we, input logic [31:0] a,
                       input logic [31:0] d);
    if (m) begin
      m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d; m1_rwtyp = 3'b010;
    end else begin
      m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d; m0_rwtyp = 3'b010;
    end
  endtask

  // Single uncontended transfer: ack expected exactly in cycle 4.
  task automatic xfer(input logic m, input logic we, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp_rd);
    push(m, exp_rd, 1'b0);
    issue(m, we, a, d);
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 3) chk("ack_early", {31'h0, m ? m1_ack : m0_ack}, 32'h0);
    end
    chk("ack_cycle4", {31'h0, m ? m1_ack : m0_ack}, 32'h1);
    if (m) m1_req = 1'b0; else m0_req = 1'b0;
    step();
  endtask

  initial begin
    int base;
    rst = 1'b1; preload = 1'b1; force_nready = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_rwtyp = 3'b0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_rwtyp = 3'b0;
    repeat (3) step();
    preload = 1'b0;
    // reset state
    chk("rst_hsel",   {31'h0, hsel}, 32'h0);
    chk("rst_hwrite", {31'h0, hwrite}, 32'h0);
    chk("rst_haddr",  haddr, 32'h0);
    chk("rst_hwdata", hwdata, 32'h0);
    chk("rst_acks",   {30'h0, m1_ack, m0_ack}, 32'h0);
    chk("rst_rdata",  m0_rdata | m1_rdata, 32'h0);
    rst = 1'b0;
    step();

    // m0 read of 0x10: address phase in cycle 1, ack in cycle 4
    push(1'b0, 32'hDEAD_BEEF, 1'b0);
    issue(1'b0, 1'b0, 32'h0000_0010, 32'h0);
    step();
    chk("rd_hsel_c1",  {31'h0, hsel}, 32'h1);
    chk("rd_haddr_c1", haddr, 32'h1000_0010);
    chk("rd_hwrite",   {31'h0, hwrite}, 32'h0);
    step();
    chk("rd_hsel_c2",  {31'h0, hsel}, 32'h0);
    chk("rd_haddr_hold", haddr, 32'h1000_0010);
    step();
    step();
    chk("rd_ack_c4",   {31'h0, m0_ack}, 32'h1);
    chk("rd_data_c4",  m0_rdata, 32'hDEAD_BEEF);
    m0_req = 1'b0;
    step();
    chk("rdata_idle_zero", m0_rdata, 32'h0);

    // m1 write 0x20: bridge writes in cycle 3, ack in cycle 4
    push(1'b1, 32'h0, 1'b0);
    issue(1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678);
    step();
    chk("wr_hwrite", {31'h0, hwrite}, 32'h1);
    step();
    step();
    chk("wr_wren_c3",  {31'h0, wren}, 32'h1);
    chk("wr_hwdata_c3", hwdata, 32'h1234_5678);
    step();
    chk("wr_ack_c4",   {31'h0, m1_ack}, 32'h1);
    chk("wr_rdata_zero", m1_rdata, 32'h0);
    m1_req = 1'b0;
    step();
    // readback
    xfer(1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'h1234_5678);

    // request dropped mid-transaction still completes with an ack
    push(1'b0, 32'h0, 1'b0);
    issue(1'b0, 1'b1, 32'h0000_0030, 32'hA5A5_A5A5);
    step();
    step();
    m0_req = 1'b0;
    step();
    step();
    chk("drop_ack_c4", {31'h0, m0_ack}, 32'h1);
    step();
    chk("drop_mem", mem[8'h30], 32'hA5A5_A5A5);

    // simultaneous requests right after reset: m0 first, m1 acked in cycle 9
    rst = 1'b1; step(); rst = 1'b0; step();
    push(1'b0, 32'hDEAD_BEEF, 1'b0);
    push(1'b1, 32'h1234_5678, 1'b0);
    issue(1'b0, 1'b0, 32'h0000_0010, 32'h0);
    issue(1'b1, 1'b0, 32'h0000_0020, 32'h0);
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 4) begin chk("both_m0_ack_c4", {31'h0, m0_ack}, 32'h1); m0_req = 1'b0; end
      if (c == 5) chk("both_hsel_idle_c5", {31'h0, hsel}, 32'h0);
      if (c == 8) chk("both_m1_early", {31'h0, m1_ack}, 32'h0);
      if (c == 9) begin chk("both_m1_ack_c9", {31'h0, m1_ack}, 32'h1); m1_req = 1'b0; end
    end
    step();

    // both held: grants must alternate m0, m1, m0, m1
    push(1'b0, 32'hDEAD_BEEF, 1'b0);
    push(1'b1, 32'h1234_5678, 1'b0);
    push(1'b0, 32'hDEAD_BEEF, 1'b0);
    push(1'b1, 32'h1234_5678, 1'b0);
    base = ack_cnt;
    issue(1'b0, 1'b0, 32'h0000_0010, 32'h0);
    issue(1'b1, 1'b0, 32'h0000_0020, 32'h0);
    for (int c = 0; c < 40; c++) begin
      step();
      if (ack_cnt - base >= 4) break;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    chk("held_ack_count", ack_cnt - base, 32'd4);
    repeat (3) step();

    // reset during WAIT of a read aborts it without an ack
    issue(1'b0, 1'b0, 32'h0000_0010, 32'h0);
    step();
    step();
    rst = 1'b1; m0_req = 1'b0;
    step();
    chk("abort_hsel",  {31'h0, hsel}, 32'h0);
    chk("abort_haddr", haddr, 32'h0);
    chk("abort_ack",   {31'h0, m0_ack}, 32'h0);
    rst = 1'b0;
    repeat (5) step();
    chk("abort_no_ack", {31'h0, m0_ack | m1_ack}, 32'h0);
    xfer(1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'h1234_5678);

`ifdef ARB_TIMEOUT_EN
    // bridge never ready: abort after 16 WAIT cycles (WAIT = cycles 2..17)
    force_nready = 1'b1;
    push(1'b0, 32'h0, 1'b1);
    issue(1'b0, 1'b0, 32'h0000_0010, 32'h0);
    for (int c = 1; c <= 18; c++) begin
      step();
      if (c == 17) chk("to_no_ack_c17", {31'h0, m0_ack}, 32'h0);
    end
    chk("to_ack_c18",   {31'h0, m0_ack}, 32'h1);
    chk("to_err_c18",   {31'h0, m0_err}, 32'h1);
    chk("to_rdata_c18", m0_rdata, 32'h0);
    m0_req = 1'b0;
    step();
    force_nready = 1'b0;
`endif

    repeat (2) step();
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
